// File: rtl/dbus_arb_pkg.sv
// Shared types for the two-master data-bus arbiter: FSM states, master IDs
// and the request bundle that is carried from a master to the slave port.
package dbus_arb_pkg;

    localparam int ARB_XLEN = 32;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY_M0,
        ARB_BUSY_M1
    } type_arb_state_e;

    typedef enum logic {
        ARB_M0,
        ARB_M1
    } type_arb_master_e;

    typedef struct packed {
        logic [ARB_XLEN-1:0] addr;
        logic [ARB_XLEN-1:0] w_data;
        logic [3:0]          sel;
        logic                ld_req;
        logic                st_req;
    } type_dbus_req_s;

    // A master raising load and store together gets the store only.
    function automatic type_dbus_req_s arb_norm_req(input type_dbus_req_s r);
        type_dbus_req_s n;
        n = r;
        if (r.st_req) begin
            n.ld_req = 1'b0;
        end
        return n;
    endfunction

endpackage

// File: rtl/dbus_arb_rr.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// master that was not granted last.
module dbus_arb_rr
    import dbus_arb_pkg::*;
(
    input  logic [1:0]       req,
    input  type_arb_master_e last_grant,
    output logic             valid,
    output type_arb_master_e grant
);

    always_comb begin
        valid = |req;
        grant = ARB_M0;
        if (req == 2'b11) begin
            grant = (last_grant == ARB_M0) ? ARB_M1 : ARB_M0;
        end else if (req == 2'b10) begin
            grant = ARB_M1;
        end
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Shares one data-memory port between the LSU (M0, with AMO lock) and a
// secondary master (M1). Define DBUS_ARB_TIMEOUT_EN to add the busy watchdog.
module dbus_arbiter
    import dbus_arb_pkg::*;
#(
    parameter int XLEN           = ARB_XLEN,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] m0_addr,
    input  logic [XLEN-1:0] m0_w_data,
    input  logic [3:0]      m0_sel,
    input  logic            m0_ld_req,
    input  logic            m0_st_req,
    input  logic            m0_lock,
    output logic            m0_ack,
    output logic [XLEN-1:0] m0_r_data,
    input  logic [XLEN-1:0] m1_addr,
    input  logic [XLEN-1:0] m1_w_data,
    input  logic [3:0]      m1_sel,
    input  logic            m1_ld_req,
    input  logic            m1_st_req,
    output logic            m1_ack,
    output logic [XLEN-1:0] m1_r_data,
    output logic [XLEN-1:0] s_addr,
    output logic [XLEN-1:0] s_w_data,
    output logic [3:0]      s_sel,
    output logic            s_ld_req,
    output logic            s_st_req,
    input  logic            s_ack,
    input  logic [XLEN-1:0] s_r_data,
    output logic            arb_err
);

    if (XLEN != ARB_XLEN || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("dbus_arbiter: XLEN must equal ARB_XLEN and TIMEOUT_CYCLES must be positive");
    end

    type_arb_state_e  state, next_state;
    type_arb_master_e last_grant, rr_grant;
    type_dbus_req_s   m0_req_s, m1_req_s, lat;
    logic             rr_valid;
    logic             pending, done, timeout;
    logic             load_m0, load_m1, clear_req;

    assign m0_req_s = '{addr: m0_addr, w_data: m0_w_data, sel: m0_sel,
                        ld_req: m0_ld_req, st_req: m0_st_req};
    assign m1_req_s = '{addr: m1_addr, w_data: m1_w_data, sel: m1_sel,
                        ld_req: m1_ld_req, st_req: m1_st_req};

    // pending is only ever set while in a BUSY state, so s_ack in IDLE is inert
    assign pending = lat.ld_req | lat.st_req;
    assign done    = pending & (s_ack | timeout);

    dbus_arb_rr u_rr (
        .req        ({m1_req_s.ld_req | m1_req_s.st_req,
                      m0_req_s.ld_req | m0_req_s.st_req}),
        .last_grant (last_grant),
        .valid      (rr_valid),
        .grant      (rr_grant)
    );

`ifdef DBUS_ARB_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : CNT_RAW;

    logic [CNT_W-1:0] wd_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (load_m0 || load_m1) begin
            wd_cnt <= '0;
        end else if (pending && !s_ack) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
        end
    end

    // Fires in the busy cycle whose increment would reach the limit
    assign timeout = pending & ~s_ack & (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign arb_err = timeout;
`else
    assign timeout = 1'b0;
    assign arb_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_IDLE;
            last_grant <= ARB_M1;
        end else begin
            state <= next_state;
            if (done) begin
                last_grant <= (state == ARB_BUSY_M0) ? ARB_M0 : ARB_M1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat <= '0;
        end else if (load_m0) begin
            lat <= arb_norm_req(m0_req_s);
        end else if (load_m1) begin
            lat <= arb_norm_req(m1_req_s);
        end else if (clear_req) begin
            lat.ld_req <= 1'b0;
            lat.st_req <= 1'b0;
        end
    end

    // Under lock, BUSY_M0 with nothing outstanding waits for M0's next access
    always_comb begin
        next_state = state;
        load_m0    = 1'b0;
        load_m1    = 1'b0;
        clear_req  = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (rr_valid) begin
                    if (rr_grant == ARB_M0) begin
                        next_state = ARB_BUSY_M0;
                        load_m0    = 1'b1;
                    end else begin
                        next_state = ARB_BUSY_M1;
                        load_m1    = 1'b1;
                    end
                end
            end
            ARB_BUSY_M0: begin
                if (pending) begin
                    if (s_ack) begin
                        clear_req = 1'b1;
                        if (!m0_lock) begin
                            next_state = ARB_IDLE;
                        end
                    end else if (timeout) begin
                        clear_req  = 1'b1;
                        next_state = ARB_IDLE;
                    end
                end else if (m0_req_s.ld_req || m0_req_s.st_req) begin
                    load_m0 = 1'b1;
                end else if (!m0_lock) begin
                    next_state = ARB_IDLE;
                end
            end
            ARB_BUSY_M1: begin
                if (done || !pending) begin
                    clear_req  = 1'b1;
                    next_state = ARB_IDLE;
                end
            end
            default: begin
                next_state = ARB_IDLE;
            end
        endcase
    end

    always_comb begin
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        m0_r_data = timeout ? '0 : s_r_data;
        m1_r_data = timeout ? '0 : s_r_data;
        case (state)
            ARB_BUSY_M0: m0_ack = done;
            ARB_BUSY_M1: m1_ack = done;
            default: begin
                m0_ack = 1'b0;
                m1_ack = 1'b0;
            end
        endcase
    end

    assign s_addr   = lat.addr;
    assign s_w_data = lat.w_data;
    assign s_sel    = lat.sel;
    assign s_ld_req = lat.ld_req;
    assign s_st_req = lat.st_req;

endmodule
